// File: rtl/hi_lo_muldiv_unit.sv
// hi_lo_muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit that feeds the register file's HI/LO
// write port directly. It captures operands on a start pulse and runs 32
// shift-add or restoring-divide steps. It then holds both write enables high
// for exactly one cycle (DONE), so the result lands in HI/LO on the next
// modified_write_clk edge.
//
// Optional feature: define MULDIV_ABORT_EN to add the 'abort' input. It
// squashes an operation in flight without producing a write.
//
// Ports:
//   modified_write_clk  clock shared with the register-file write port
//   reset               asynchronous, active-high
//   start               request, sampled only while idle
//   abort               (MULDIV_ABORT_EN only) return to idle, no write
//   op                  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a           rs: multiplicand / dividend
//   operand_b           rt: multiplier / divisor
//   busy                high while an operation is running or completing
//   HI/LO_write_enable  one-cycle pulse while the result is presented
//   HI_write_data       product[63:32] or remainder
//   LO_write_data       product[31:0] or quotient
module hi_lo_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 5
) (
  input  logic             modified_write_clk,
  input  logic             reset,
  input  logic             start,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             HI_write_enable,
  output logic             LO_write_enable,
  output logic [WIDTH-1:0] HI_write_data,
  output logic [WIDTH-1:0] LO_write_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t state_q, state_d;

  logic [COUNT_W-1:0] counter_q;
  logic [1:0]         op_q;
  logic               sign_a_q, sign_b_q, div_zero_q;
  logic [WIDTH-1:0]   orig_a_q;
  // Multiplicand (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]   step_operand_q;
  // {acc_hi, acc_lo}: product accumulator with multiplier in the low half,
  // or partial remainder in the high half and dividend/quotient in the low half.
  logic [WIDTH-1:0]   acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0]   hi_data_q, lo_data_q;

  logic abort_hit;
`ifdef MULDIV_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  logic last_step;
  assign last_step = (counter_q == COUNT_W'(WIDTH - 1));

  // Operand magnitudes for capture; ops with op[0]==0 are signed.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  always_comb begin
    a_neg = ~op[0] & operand_a[WIDTH-1];
    b_neg = ~op[0] & operand_b[WIDTH-1];
    mag_a = a_neg ? -operand_a : operand_a;
    mag_b = b_neg ? -operand_b : operand_b;
  end

  // One iteration of each algorithm, computed from the current accumulator.
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   step_hi, step_lo;
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} +
                (acc_lo_q[0] ? {1'b0, step_operand_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, step_operand_q});
    if (op_q[1]) begin
      // The remainder is always below the divisor, so a WIDTH-bit subtract is exact.
      step_hi = div_ge ? (div_shift[WIDTH-1:0] - step_operand_q) : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied to the final step's result as it enters DONE.
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   final_hi, final_lo;
  always_comb begin
    product  = {step_hi, step_lo};
    final_hi = step_hi;
    final_lo = step_lo;
    if (!op_q[1]) begin
      if (!op_q[0] && (sign_a_q ^ sign_b_q)) begin
        product = -product;
      end
      final_hi = product[2*WIDTH-1:WIDTH];
      final_lo = product[WIDTH-1:0];
    end else if (div_zero_q) begin
      final_hi = orig_a_q;
      final_lo = {WIDTH{1'b1}};
    end else if (!op_q[0]) begin
      if (sign_a_q ^ sign_b_q) final_lo = -step_lo;
      if (sign_a_q)            final_hi = -step_hi;
    end
  end

  always_ff @(posedge modified_write_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !abort_hit) state_d = ST_BUSY;
      ST_BUSY: begin
        if (abort_hit)      state_d = ST_IDLE;
        else if (last_step) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge modified_write_clk or posedge reset) begin
    if (reset) begin
      counter_q      <= '0;
      op_q           <= '0;
      sign_a_q       <= 1'b0;
      sign_b_q       <= 1'b0;
      div_zero_q     <= 1'b0;
      orig_a_q       <= '0;
      step_operand_q <= '0;
      acc_hi_q       <= '0;
      acc_lo_q       <= '0;
      hi_data_q      <= '0;
      lo_data_q      <= '0;
    end else begin
      if (state_q == ST_IDLE && start && !abort_hit) begin
        counter_q      <= '0;
        op_q           <= op;
        sign_a_q       <= a_neg;
        sign_b_q       <= b_neg;
        div_zero_q     <= op[1] && (operand_b == '0);
        orig_a_q       <= operand_a;
        acc_hi_q       <= '0;
        step_operand_q <= op[1] ? mag_b : mag_a;
        acc_lo_q       <= op[1] ? mag_a : mag_b;
      end else if (state_q == ST_BUSY && !abort_hit) begin
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        if (last_step) begin
          hi_data_q <= final_hi;
          lo_data_q <= final_lo;
        end else begin
          counter_q <= counter_q + COUNT_W'(1);
        end
      end
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign HI_write_enable = (state_q == ST_DONE);
  assign LO_write_enable = (state_q == ST_DONE);
  assign HI_write_data   = hi_data_q;
  assign LO_write_data   = lo_data_q;

endmodule
